fp16_normalizer: RTL and testbench

Converts the signed fixed-point sum produced by the SD4 MAC alignment/accumulation path back into an IEEE FP16 word. It sits after the adder tree and is the reverse of alignment: it takes a two's-complement aligned sum plus the shared maximum exponent and renormalizes it into sign/exponent/mantissa. Subnormal output and overflow-to-infinity are handled here. The normalizer is iterative, one shift per cycle, with valid/ready handshakes on both sides.

---
 rtl/fp16_normalizer.sv | 114 +++++++++++
 tb/tb_fp16_normalizer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fp16_normalizer.sv
// Iterative renormalizer that turns an aligned two's-complement sum plus a shared exponent into FP16.
// Define NORM_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp16_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic [4:0]  in_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  typedef enum logic [1:0] {StIdle, StShift, StRound, StDone} state_e;

  state_e      state;
  logic        sign;
  logic [16:0] mag;
  logic [6:0]  exp;
  logic        guard;
  logic        sticky;

  logic [16:0] mag_in;
  logic [6:0]  exp_in;
  logic [11:0] mant_rnd;
  logic [6:0]  exp_rnd;
  logic [4:0]  exp_field;
  logic [15:0] round_out;

  // 0x8000 maps to exactly 32768, hence the 17-bit magnitude.
  always_comb begin
    mag_in = in_sum[15] ? (17'h10000 - {1'b0, in_sum}) : {1'b0, in_sum};
    exp_in = (in_exp == 5'd0) ? 7'd1 : {2'b00, in_exp};
  end

  always_comb begin
    mant_rnd = {1'b0, mag[10:0]};
`ifdef NORM_RNE_EN
    if (guard & (sticky | mag[0])) mant_rnd = mant_rnd + 12'd1;
`endif
    exp_rnd = exp;
    if (mant_rnd[11]) begin
      mant_rnd = 12'h400;
      exp_rnd  = exp + 7'd1;
    end
    // A subnormal that carries into bit 10 picks up exponent 1 from exp here.
    exp_field = mant_rnd[10] ? exp_rnd[4:0] : 5'd0;
    if (mag == 17'd0) begin
      round_out = 16'h0000;
    end else if (exp_rnd >= 7'd31) begin
      round_out = {sign, 5'h1f, 10'h000};
    end else begin
      round_out = {sign, exp_field, mant_rnd[9:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= 16'h0000;
      sign      <= 1'b0;
      mag       <= 17'd0;
      exp       <= 7'd0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            sign     <= in_sum[15];
            mag      <= mag_in;
            exp      <= exp_in;
            guard    <= 1'b0;
            sticky   <= 1'b0;
            in_ready <= 1'b0;
            state    <= StShift;
          end
        end
        StShift: begin
          if (mag == 17'd0) begin
            state <= StRound;
          end else if (mag[16:11] != 6'd0) begin
            sticky <= sticky | guard;
            guard  <= mag[0];
            mag    <= mag >> 1;
            exp    <= exp + 7'd1;
          end else if (!mag[10] && (exp > 7'd1)) begin
            mag <= mag << 1;
            exp <= exp - 7'd1;
          end else begin
            state <= StRound;
          end
        end
        StRound: begin
          out       <= round_out;
          out_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_normalizer.sv
// Self-checking bench for fp16_normalizer: directed cases, handshake/reset checks and random ops
// against an arithmetic FP16 reference model (honours NORM_RNE_EN).
module tb_fp16_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic [4:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;

  fp16_normalizer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_exp   (in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Value = |sum| * 2^(e-25); normalise to an 11-bit significand with the leading one at bit 10.
  function automatic logic [15:0] ref_fp16(input logic [15:0] s, input logic [4:0] ein,
                                           output int lat);
    int mag, e, p, sh, mant, dropped, half;
    logic [4:0] ef;
    mag = s[15] ? (65536 - int'(s)) : int'(s);
    e   = (ein == 0) ? 1 : int'(ein);
    if (mag == 0) begin
      lat = 2;
      return 16'h0000;
    end
    p = 0;
    for (int i = 0; i < 17; i++) if ((mag >> i) & 1) p = i;
    if (p > 10) begin
      sh      = p - 10;
      dropped = mag % (1 << sh);
      mant    = mag >> sh;
      e       = e + sh;
      half    = 1 << (sh - 1);
`ifdef NORM_RNE_EN
      if (dropped > half || (dropped == half && (mant % 2) == 1)) mant++;
`endif
    end else begin
      sh   = ((10 - p) < (e - 1)) ? (10 - p) : (e - 1);
      mant = mag << sh;
      e    = e - sh;
    end
    lat = 2 + sh;
    if (mant == 2048) begin
      mant = 1024;
      e++;
    end
    if (e >= 31) return {s[15], 5'h1f, 10'h000};
    ef = (mant >= 1024) ? 5'(e) : 5'd0;
    return {s[15], ef, 10'(mant)};
  endfunction

  task automatic run_op(input logic [15:0] s, input logic [4:0] e, input int hold,
                        input string tag);
    logic [15:0] want;
    int          want_lat;
    int          lat;
    logic        rdy_ok;
    want = ref_fp16(s, e, want_lat);
    @(negedge clk);
    check({tag, " ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    in_sum   = s;
    in_exp   = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = $urandom;
    in_exp   = $urandom;
    lat      = 0;
    rdy_ok   = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " ready_low"}, rdy_ok, 1);
    check({tag, " latency"}, lat, want_lat);
    check({tag, " out"}, out, want);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (out !== want || !out_valid || in_ready) rdy_ok = 1'b0;
    end
    if (hold > 0) check({tag, " hold_stable"}, rdy_ok, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, out_valid, 0);
    check({tag, " ready_back"}, in_ready, 1);
    check({tag, " out_held"}, out, want);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = 16'h0;
    in_exp    = 5'h0;
    out_ready = 1'b0;
    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out", out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h0400, 5'd15, 0, "one");
    run_op(16'hfc00, 5'd15, 0, "minus_one");
    run_op(16'h0000, 5'd20, 0, "zero");
    run_op(16'h0001, 5'd15, 0, "tiny_left10");
    run_op(16'h0001, 5'd3, 0, "subnormal");
    run_op(16'h7fff, 5'd30, 0, "overflow");
    run_op(16'h8000, 5'd1, 0, "most_neg");
    run_op(16'h0fff, 5'd15, 0, "round_carry");
    run_op(16'h03ff, 5'd0, 0, "exp0_sub");
    run_op(16'h0400, 5'd31, 0, "exp31_inf");
    run_op(16'h1234, 5'd10, 20, "hold");

    // Abort mid-operation: the reset clears everything and no result appears.
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = 16'h0001;
    in_exp   = 5'd15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort out", out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0fff, 5'd15, 0, "after_abort");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] rs;
      logic [4:0]  re;
      rs = 16'($urandom);
      re = 5'($urandom_range(0, 31));
      if (n % 4 == 0) rs = 16'($urandom_range(0, 63)) ^ {16{rs[15]}};
      run_op(rs, re, n % 7, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
